periph_port_arbiter: RTL and testbench

PERIPH_PORT_ARBITER -- requirements
Module: periph_port_arbiter

---
 rtl/periph_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_periph_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_port_arbiter.sv
// Round-robin arbiter funnelling NB_MASTERS cores onto one peripheral port,
// one transaction in flight, with optional target-grant timeout.
module periph_port_arbiter #(
  parameter int NB_MASTERS     = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NB_MASTERS-1:0]                  mst_req_i,
  input  logic [NB_MASTERS-1:0][ADDR_WIDTH-1:0]  mst_add_i,
  input  logic [NB_MASTERS-1:0]                  mst_wen_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH-1:0]  mst_wdata_i,
  input  logic [NB_MASTERS-1:0][DATA_WIDTH/8-1:0] mst_be_i,
  output logic [NB_MASTERS-1:0]                  mst_gnt_o,
  output logic [NB_MASTERS-1:0]                  mst_r_valid_o,
  output logic [DATA_WIDTH-1:0]                  mst_r_rdata_o,
  output logic                                   mst_r_opc_o,
  output logic                                   per_req_o,
  output logic [ADDR_WIDTH-1:0]                  per_add_o,
  output logic                                   per_wen_o,
  output logic [DATA_WIDTH-1:0]                  per_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                per_be_o,
  input  logic                                   per_gnt_i,
  input  logic                                   per_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                  per_r_rdata_i,
  input  logic                                   per_r_opc_i,
  output logic                                   busy_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NB_MASTERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_MASTERS - 1);
  localparam logic [IDX_W:0]   NB_EXT   = (IDX_W + 1)'(NB_MASTERS);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_q, owner_q, sel_idx, next_rr;
  logic                    sel_vld, timeout_hit;
  logic [ADDR_WIDTH-1:0]   add_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [BE_W-1:0]         be_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NB_MASTERS-1:0]   rvalid_q;
  logic                    opc_q;

  // First requester at or after rr_q, scanning circularly.
  always_comb begin
    logic [IDX_W:0] j;
    sel_vld = 1'b0;
    sel_idx = '0;
    j       = '0;
    for (int unsigned i = 0; i < NB_MASTERS; i++) begin
      j = {1'b0, rr_q} + (IDX_W + 1)'(i);
      if (j >= NB_EXT) j = j - NB_EXT;
      if (!sel_vld && mst_req_i[j[IDX_W-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = j[IDX_W-1:0];
      end
    end
  end

  assign next_rr     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == REQ) && !per_gnt_i && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    mst_gnt_o = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = REQ;
          if (!rst_i) mst_gnt_o[sel_idx] = 1'b1;
        end
      end
      REQ: begin
        if (per_gnt_i)        state_d = RSP;
        else if (timeout_hit) state_d = IDLE;
      end
      RSP: begin
        if (per_r_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      add_q    <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      opc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            owner_q <= sel_idx;
            add_q   <= mst_add_i[sel_idx];
            wen_q   <= mst_wen_i[sel_idx];
            wdata_q <= mst_wdata_i[sel_idx];
            be_q    <= mst_be_i[sel_idx];
            cnt_q   <= '0;
          end
        end
        REQ: begin
          // Counter stops at TIMEOUT_CYCLES because the state leaves REQ there.
          if (!per_gnt_i && (TIMEOUT_CYCLES > 0)) cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            rvalid_q[owner_q] <= 1'b1;
            rdata_q           <= '0;
            opc_q             <= 1'b1;
            rr_q              <= next_rr;
          end
        end
        RSP: begin
          if (per_r_valid_i) begin
            rvalid_q[owner_q] <= 1'b1;
            rdata_q           <= per_r_rdata_i;
            opc_q             <= per_r_opc_i;
            rr_q              <= next_rr;
          end
        end
        default: ;
      endcase
    end
  end

  assign mst_r_valid_o = rvalid_q;
  assign mst_r_rdata_o = rdata_q;
  assign mst_r_opc_o   = opc_q;
  assign per_req_o     = (state_q == REQ);
  assign per_add_o     = add_q;
  assign per_wen_o     = wen_q;
  assign per_wdata_o   = wdata_q;
  assign per_be_o      = be_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_periph_port_arbiter.sv
// Directed bench: default-timeout arbiter plus a TIMEOUT_CYCLES=4 copy,
// responses checked against a scoreboard queue.
module tb_periph_port_arbiter;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [7:0]        mst_req_i, mst_wen_i;
  logic [7:0][31:0]  mst_add_i, mst_wdata_i;
  logic [7:0][3:0]   mst_be_i;
  logic              per_gnt_i, per_r_valid_i, per_r_opc_i;
  logic [31:0]       per_r_rdata_i;

  logic [7:0]  d_gnt, d_rvalid, t_gnt, t_rvalid;
  logic [31:0] d_rdata, d_per_add, d_per_wdata, t_rdata, t_per_add, t_per_wdata;
  logic        d_opc, d_per_req, d_per_wen, d_busy, t_opc, t_per_req, t_per_wen, t_busy;
  logic [3:0]  d_per_be, t_per_be;

  int tests = 0;
  int fails = 0;
  bit mon_sel = 1'b0;

  typedef struct { int m; logic [31:0] d; logic o; } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  periph_port_arbiter u_dut (
    .clk_i(clk), .rst_i(rst_i), .mst_req_i(mst_req_i), .mst_add_i(mst_add_i),
    .mst_wen_i(mst_wen_i), .mst_wdata_i(mst_wdata_i), .mst_be_i(mst_be_i),
    .mst_gnt_o(d_gnt), .mst_r_valid_o(d_rvalid), .mst_r_rdata_o(d_rdata), .mst_r_opc_o(d_opc),
    .per_req_o(d_per_req), .per_add_o(d_per_add), .per_wen_o(d_per_wen),
    .per_wdata_o(d_per_wdata), .per_be_o(d_per_be), .per_gnt_i(per_gnt_i),
    .per_r_valid_i(per_r_valid_i), .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i),
    .busy_o(d_busy)
  );

  periph_port_arbiter #(.TIMEOUT_CYCLES(4)) u_to (
    .clk_i(clk), .rst_i(rst_i), .mst_req_i(mst_req_i), .mst_add_i(mst_add_i),
    .mst_wen_i(mst_wen_i), .mst_wdata_i(mst_wdata_i), .mst_be_i(mst_be_i),
    .mst_gnt_o(t_gnt), .mst_r_valid_o(t_rvalid), .mst_r_rdata_o(t_rdata), .mst_r_opc_o(t_opc),
    .per_req_o(t_per_req), .per_add_o(t_per_add), .per_wen_o(t_per_wen),
    .per_wdata_o(t_per_wdata), .per_be_o(t_per_be), .per_gnt_i(per_gnt_i),
    .per_r_valid_i(per_r_valid_i), .per_r_rdata_i(per_r_rdata_i), .per_r_opc_i(per_r_opc_i),
    .busy_o(t_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every r_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [7:0]  rv;
    logic [31:0] rd;
    logic        op;
    exp_t        e;
    rv = mon_sel ? t_rvalid : d_rvalid;
    rd = mon_sel ? t_rdata  : d_rdata;
    op = mon_sel ? t_opc    : d_opc;
    if (rv != 8'h00) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rvalid", 64'(rv), 64'h0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_owner", 64'(rv), 64'(1) << e.m);
        chk("rsp_rdata", 64'(rd), 64'(e.d));
        chk("rsp_opc",   64'(op), 64'(e.o));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcount[8];
    foreach (gcount[i]) gcount[i] = 0;
    rst_i = 1'b1; mst_req_i = 8'hFF; mst_wen_i = '0; mst_add_i = '0;
    mst_wdata_i = '0; mst_be_i = '0; per_gnt_i = 1'b0; per_r_valid_i = 1'b0;
    per_r_opc_i = 1'b0; per_r_rdata_i = '0;
    for (int i = 0; i < 8; i++) mst_add_i[i] = 32'h1000_0000 + 32'(i * 16);

    // Reset state, grant suppressed while rst_i is high.
    repeat (3) cyc();
    #1;
    chk("rst_gnt",     64'(d_gnt), 64'h0);
    chk("rst_gnt_to",  64'(t_gnt), 64'h0);
    chk("rst_busy",    64'(d_busy), 64'h0);
    chk("rst_per_req", 64'(d_per_req), 64'h0);
    chk("rst_rvalid",  64'(d_rvalid), 64'h0);
    chk("rst_rdata",   64'(d_rdata), 64'h0);
    chk("rst_opc",     64'(d_opc), 64'h0);
    chk("rst_per_add", 64'(d_per_add), 64'h0);
    rst_i = 1'b0; mst_req_i = '0;
    cyc();

    // Fairness: everyone requests, target answers immediately.
    mst_req_i = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      int m;
      m = k % 8;
      #1;
      chk($sformatf("fair_gnt%0d", k), 64'(d_gnt), 64'(1) << m);
      for (int i = 0; i < 8; i++) gcount[i] += int'(d_gnt[i]);
      cyc(); per_gnt_i = 1'b1; #1;
      chk($sformatf("fair_add%0d", k), 64'(d_per_add), 64'(32'h1000_0000 + 32'(m * 16)));
      cyc(); per_gnt_i = 1'b0; per_r_valid_i = 1'b1; per_r_rdata_i = 32'hD000_0000 + 32'(k);
      sb_q.push_back('{m, 32'hD000_0000 + 32'(k), 1'b0});
      cyc(); per_r_valid_i = 1'b0;
      if (k == 8) mst_req_i = '0;
    end
    for (int i = 0; i < 8; i++) chk($sformatf("fair_count%0d", i), 64'(gcount[i]), (i == 0) ? 64'd2 : 64'd1);

    // Single read from master 3 at minimum latency.
    cyc();
    mst_req_i = 8'h08; mst_add_i[3] = 32'h1020_4000; mst_wen_i[3] = 1'b1; mst_be_i[3] = 4'hF;
    #1; chk("rd_gnt", 64'(d_gnt), 64'h08);
    cyc(); mst_req_i = '0; per_gnt_i = 1'b1; #1;
    chk("rd_per_req", 64'(d_per_req), 64'h1);
    chk("rd_per_add", 64'(d_per_add), 64'h1020_4000);
    chk("rd_per_wen", 64'(d_per_wen), 64'h1);
    chk("rd_per_be",  64'(d_per_be), 64'hF);
    cyc(); per_gnt_i = 1'b0; per_r_valid_i = 1'b1; per_r_rdata_i = 32'hCAFE_0001; per_r_opc_i = 1'b0;
    sb_q.push_back('{3, 32'hCAFE_0001, 1'b0});
    #1; chk("rd_rsp_req", 64'(d_per_req), 64'h0);
    chk("rd_rsp_busy", 64'(d_busy), 64'h1);
    cyc(); per_r_valid_i = 1'b0; #1;
    chk("rd_rvalid_c3", 64'(d_rvalid), 64'h08);
    chk("rd_idle_busy", 64'(d_busy), 64'h0);

    // Back-pressure: 10 cycles without target grant.
    cyc();
    mst_req_i = 8'h30; mst_add_i[4] = 32'hABCD_0040; mst_wen_i[4] = 1'b0; mst_wdata_i[4] = 32'h1234_5678;
    #1; chk("bp_gnt", 64'(d_gnt), 64'h10);
    cyc(); mst_req_i = 8'h20; per_gnt_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("bp_req%0d", i), 64'(d_per_req), 64'h1);
      chk($sformatf("bp_add%0d", i), 64'(d_per_add), 64'hABCD_0040);
      chk($sformatf("bp_nognt%0d", i), 64'(d_gnt), 64'h0);
      cyc();
    end
    per_gnt_i = 1'b1; #1;
    chk("bp_req10", 64'(d_per_req), 64'h1);
    chk("bp_wdata", 64'(d_per_wdata), 64'h1234_5678);
    cyc(); per_gnt_i = 1'b0; per_r_valid_i = 1'b1; per_r_rdata_i = 32'h0BAD_F00D; per_r_opc_i = 1'b1;
    sb_q.push_back('{4, 32'h0BAD_F00D, 1'b1});
    cyc(); per_r_valid_i = 1'b0; per_r_opc_i = 1'b0; #1;
    chk("bp_next_gnt", 64'(d_gnt), 64'h20);
    mst_req_i = '0;
    cyc(); #1;
    chk("skip_busy", 64'(d_busy), 64'h0);

    // Reset while master 5 waits for its response.
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    mst_req_i = 8'h20; #1;
    chk("rr5_gnt", 64'(d_gnt), 64'h20);
    cyc(); mst_req_i = '0; per_gnt_i = 1'b1;
    cyc(); per_gnt_i = 1'b0; #1;
    chk("rr5_rsp_busy", 64'(d_busy), 64'h1);
    rst_i = 1'b1; mst_req_i = 8'h44; mst_add_i[2] = 32'h2222_0000;
    per_r_valid_i = 1'b1; per_r_rdata_i = 32'h5555_5555; #1;
    chk("rst_mid_gnt", 64'(d_gnt), 64'h0);
    cyc(); rst_i = 1'b0; #1;
    chk("post_rst_rvalid", 64'(d_rvalid), 64'h0);
    chk("post_rst_gnt", 64'(d_gnt), 64'h04);
    cyc(); per_r_valid_i = 1'b0; mst_req_i = 8'h40; per_gnt_i = 1'b1; #1;
    chk("m2_rvalid_none", 64'(d_rvalid), 64'h0);
    chk("m2_per_add", 64'(d_per_add), 64'h2222_0000);
    cyc(); per_gnt_i = 1'b0; per_r_valid_i = 1'b1; per_r_rdata_i = 32'h2222_AAAA;
    sb_q.push_back('{2, 32'h2222_AAAA, 1'b0});
    cyc(); per_r_valid_i = 1'b0; #1;
    chk("m6_gnt", 64'(d_gnt), 64'h40);
    mst_req_i = '0;
    cyc();

    // Timeout on the TIMEOUT_CYCLES=4 instance.
    mon_sel = 1'b1;
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    mst_req_i = 8'h01; #1;
    chk("to_gnt", 64'(t_gnt), 64'h01);
    cyc(); mst_req_i = '0; per_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; chk($sformatf("to_req%0d", i), 64'(t_per_req), 64'h1);
      cyc();
    end
    #1;
    sb_q.push_back('{0, 32'h0, 1'b1});
    chk("to_req_drop", 64'(t_per_req), 64'h0);
    chk("to_rvalid",   64'(t_rvalid), 64'h01);
    chk("to_opc",      64'(t_opc), 64'h1);
    chk("to_rdata",    64'(t_rdata), 64'h0);
    mst_req_i = 8'h02; #1;
    chk("to2_gnt", 64'(t_gnt), 64'h02);
    cyc(); mst_req_i = '0;
    for (int i = 0; i < 3; i++) begin
      #1; chk($sformatf("to2_req%0d", i), 64'(t_per_req), 64'h1);
      cyc();
    end
    per_gnt_i = 1'b1; #1;
    chk("to2_req3", 64'(t_per_req), 64'h1);
    cyc(); per_gnt_i = 1'b0; #1;
    chk("to2_rsp_req", 64'(t_per_req), 64'h0);
    chk("to2_rsp_busy", 64'(t_busy), 64'h1);
    per_r_valid_i = 1'b1; per_r_rdata_i = 32'h5555_0001; per_r_opc_i = 1'b0;
    sb_q.push_back('{1, 32'h5555_0001, 1'b0});
    cyc(); per_r_valid_i = 1'b0; #1;
    chk("to2_rvalid", 64'(t_rvalid), 64'h02);
    chk("to2_opc", 64'(t_opc), 64'h0);
    cyc(); cyc();
    chk("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
